// File: rtl/or_bus_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and the shared result bus.
// The req_lock signal exists only when ARB_LOCK_EN is defined.
interface or_bus_arbiter_if #(
  parameter int WIDTH        = 32,
  parameter int REQ_QUANTITY = 4
);
  localparam int ID_W = $clog2(REQ_QUANTITY);

  logic [REQ_QUANTITY-1:0]       req_valid;
  logic [WIDTH*REQ_QUANTITY-1:0] req_data;
  logic [REQ_QUANTITY-1:0]       req_ready;
`ifdef ARB_LOCK_EN
  logic [REQ_QUANTITY-1:0]       req_lock;
`endif
  logic                          out_valid;
  logic [WIDTH-1:0]              out_data;
  logic [ID_W-1:0]               out_id;
  logic                          out_ready;

`ifdef ARB_LOCK_EN
  modport master (
    output req_valid, req_data, req_lock, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
  modport slave (
    input  req_valid, req_data, req_lock, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
`else
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
`endif
endinterface

// File: rtl/or_bus_arbiter.sv
// Round-robin arbiter driving one registered result bus through an AND-OR mux.
// Define ARB_LOCK_EN to compile in burst locking (req_lock, locked, owner).
module large_fan_in_or #(
  parameter int WIDTH       = 32,
  parameter int OR_QUANTITY = 4
) (
  input  logic [WIDTH*OR_QUANTITY-1:0] data,
  output logic [WIDTH-1:0]             result
);
  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < OR_QUANTITY; i++)
      result = result | data[i*WIDTH +: WIDTH];
  end
endmodule

module or_bus_arbiter #(
  parameter int WIDTH        = 32,
  parameter int REQ_QUANTITY = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  or_bus_arbiter_if.slave bus
);
  localparam int N    = REQ_QUANTITY;
  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    ptr_next;
  logic               found;
  logic               accept;
  logic               xfer;
  logic [N-1:0]       eligible;
  logic [N-1:0]       grant;
  logic [WIDTH*N-1:0] masked;
  logic [WIDTH-1:0]   mux_data;

  logic               valid_q;
  logic [WIDTH-1:0]   data_q;
  logic [ID_W-1:0]    id_q;

`ifdef ARB_LOCK_EN
  logic               locked;
  logic [ID_W-1:0]    owner;

  // While locked only the owner may win, even when it is idle.
  always_comb begin
    eligible = bus.req_valid;
    if (locked)
      eligible = bus.req_valid & (N'(1) << owner);
  end
`else
  always_comb eligible = bus.req_valid;
`endif

  // Ascending search from ptr with wrap; sum stays below 2N so one subtraction folds it.
  always_comb begin
    logic [ID_W:0] sum;
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N))
        sum = sum - (ID_W+1)'(N);
      idx = sum[ID_W-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found)
      grant[win_id] = 1'b1;
  end

  always_comb begin
    ptr_next = win_id + 1'b1;
    if (win_id == ID_W'(N-1))
      ptr_next = '0;
  end

  assign accept        = !valid_q | bus.out_ready;
  assign xfer          = found & accept;
  assign bus.req_ready = grant & {N{accept}};

  always_comb begin
    masked = '0;
    for (int unsigned j = 0; j < N; j++)
      masked[j*WIDTH +: WIDTH] = bus.req_data[j*WIDTH +: WIDTH] & {WIDTH{grant[j]}};
  end

  large_fan_in_or #(
    .WIDTH       (WIDTH),
    .OR_QUANTITY (N)
  ) u_fan_in_or (
    .data   (masked),
    .result (mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= mux_data;
      id_q    <= win_id;
      ptr     <= ptr_next;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
      owner  <= '0;
    end else if (xfer) begin
      locked <= bus.req_lock[win_id];
      if (bus.req_lock[win_id])
        owner <= win_id;
    end
  end
`endif

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
endmodule
